// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier and restoring divider, one bit per cycle.
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULT/DIV via magnitude datapath plus a FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw;
    logic               b_zero;
    logic               fix_en;
    logic               neg_prod;
    logic               neg_rem;
    logic               is_div;

    logic               signed_op;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = op[0] & ~op[2];
`else
    assign signed_op = 1'b0;
`endif
    assign sa    = signed_op & a[WIDTH-1];
    assign sb    = signed_op & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    // The subtraction fits WIDTH bits whenever it is kept, since the result is below the divisor.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_diff  = div_shift[WIDTH-1:0] - opb;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge reset_n) begin
        // NOTE: every register is reset, including the datapath, so a mid-operation reset leaves no residue.
        if (!reset_n) begin
            state       <= S_IDLE;
            count       <= '0;
            acc         <= '0;
            opb         <= '0;
            a_raw       <= '0;
            b_zero      <= 1'b0;
            fix_en      <= 1'b0;
            neg_prod    <= 1'b0;
            neg_rem     <= 1'b0;
            is_div      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                state       <= op[1] ? S_DIV : S_MUL;
                                busy        <= 1'b1;
                                count       <= '0;
                                div_by_zero <= 1'b0;
                                acc         <= {{WIDTH{1'b0}}, mag_a};
                                opb         <= mag_b;
                                a_raw       <= a;
                                is_div      <= op[1];
                                b_zero      <= op[1] && (b == '0);
                                fix_en      <= signed_op;
                                neg_prod    <= sa ^ sb;
                                neg_rem     <= sa;
                            end
                            OP_MTHI: begin
                                hi          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (state == S_MUL)
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    else
                        acc <= {div_ge ? div_diff : div_shift[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= fix_en ? S_FIX : S_DONE;
                        busy  <= fix_en;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        if (neg_prod)
                            acc <= -acc;
                    end else if (!b_zero) begin
                        acc <= {neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                                neg_prod ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0]};
                    end
                    state <= S_DONE;
                    busy  <= 1'b0;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    if (b_zero) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= acc[2*WIDTH-1:WIDTH];
                        lo <= acc[WIDTH-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Signed-op expectations follow MULDIV_SIGNED_EN as defined for the compile.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    int seen;

    always #5 Clk = ~Clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a request for one edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Cycles from the accepting edge until done, and how many of those samples had busy high.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = busy ? 1 : 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (busy) nb++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int exp_lat, input int exp_busy);
        issue(o, x, y);
        wait_done(lat, bcnt);
        check({tag, "_latency"}, W'(lat), W'(exp_lat));
        check({tag, "_busy_cycles"}, W'(bcnt), W'(exp_busy));
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        a       = '0;
        b       = '0;
        #12;
        check("reset_busy", W'(busy), 0);
        check("reset_done", W'(done), 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_dbz", W'(div_by_zero), 0);
        #3 reset_n = 1'b1;
        tick();

        // MULTU max operands
        run("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 32);

        // DIVU normal, then divide by zero
        run("divu_100_7", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32);
        check("divu_100_7_dbz", W'(div_by_zero), 0);
        run("divu_by0", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33, 32);
        check("divu_by0_dbz", W'(div_by_zero), 1);

        // Flag clears on acceptance; hi/lo hold during the operation
        issue(3'b000, 32'd9, 32'd9);
        check("dbz_clear", W'(div_by_zero), 0);
        check("hold_busy", W'(busy), 1);
        repeat (5) tick();
        check("hold_hi", hi, 32'd5);
        check("hold_lo", lo, 32'hFFFFFFFF);
        wait_done(lat, bcnt);
        check("mul9x9_lo", lo, 32'd81);
        tick();

        // Reserved op is ignored
        issue(3'b110, 32'h55, 32'h1);
        check("rsvd_busy", W'(busy), 0);
        check("rsvd_done", W'(done), 0);
        check("rsvd_hi", hi, 32'd0);
        tick();
        check("rsvd_done_late", W'(done), 0);

        // MULT: signed with the feature on, unsigned otherwise
`ifdef MULDIV_SIGNED_EN
        run("mult_neg", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 34, 33);
        run("div_neg7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
        run("div_min_m1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33);
        run("div_signed_by0", 3'b011, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 34, 33);
        check("div_signed_by0_dbz", W'(div_by_zero), 1);
`else
        run("mult_unsigned", 3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 33, 32);
        run("div_unsigned", 3'b011, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 33, 32);
`endif

        // Start while busy is ignored
        issue(3'b000, 32'd3, 32'd5);
        repeat (3) tick();
        start = 1'b1;
        op    = 3'b010;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_ignore_lat", W'(lat + 4), 33);
        check("busy_ignore_hi", hi, 32'd0);
        check("busy_ignore_lo", lo, 32'd15);

        // Back-to-back start during the done cycle
        check("b2b_done_high", W'(done), 1);
        issue(3'b000, 32'd6, 32'd7);
        check("b2b_accept_busy", W'(busy), 1);
        check("b2b_accept_done", W'(done), 0);
        wait_done(lat, bcnt);
        check("b2b_lat", W'(lat), 33);
        check("b2b_lo", lo, 32'd42);
        tick();

        // MTLO
        issue(3'b101, 32'hCAFEF00D, 32'h0);
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_done", W'(done), 1);
        check("mtlo_busy", W'(busy), 0);
        tick();
        check("mtlo_done_drop", W'(done), 0);

        // Asynchronous reset mid-operation
        issue(3'b000, 32'h1234, 32'h5678);
        repeat (9) tick();
        check("pre_reset_busy", W'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", W'(busy), 0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_done", W'(done), 0);
        repeat (2) tick();
        #3 reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (done || busy) seen++;
        end
        check("post_rst_quiet", W'(seen), 0);

        // MTHI after reset
        issue(3'b100, 32'h12345678, 32'h0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_done", W'(done), 1);
        check("mthi_busy", W'(busy), 0);
        tick();
        check("mthi_done_drop", W'(done), 0);
        check("mthi_busy_late", W'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
